// File: rtl/cpu_bus_dma_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_bus_dma_ctrl
// CPU-side bus controller. Decodes the 16-bit CPU address into mirrored work
// RAM, the PPU register window and the cartridge port. It also contains an OAM
// DMA engine: a CPU write to DMA_ADDR halts the CPU and copies DMA_LEN bytes
// from page {data,8'h00} into PPU OAMDATA.
//
// Ports
//   clock, reset_n       system clock, asynchronous active-low reset
//   clock_en             CPU cycle strobe; all state advances only when high
//   cpu_addr/cpu_r_en    CPU address and direction (1 read, 0 write)
//   cpu_w_data           CPU write data
//   cpu_r_data           registered read data (1-cycle latency, open bus hold)
//   cpu_halt/dma_active  high while the DMA engine owns the bus
//   reg_sel/reg_en/reg_rw/reg_data_wr/reg_data_rd   PPU register port
//   cart_addr/cart_r_en/cart_w_en/cart_w_data/cart_r_data   cartridge port
// -----------------------------------------------------------------------------
package cpu_bus_dma_ctrl_pkg;
  typedef enum logic [2:0] {
    PPUCTRL   = 3'd0,
    PPUMASK   = 3'd1,
    PPUSTATUS = 3'd2,
    OAMADDR   = 3'd3,
    OAMDATA   = 3'd4,
    PPUSCROLL = 3'd5,
    PPUADDR   = 3'd6,
    PPUDATA   = 3'd7
  } reg_t;
endpackage

module cpu_bus_dma_ctrl
  import cpu_bus_dma_ctrl_pkg::*;
#(
  parameter int          RAM_AW    = 11,
  parameter logic [15:0] DMA_ADDR  = 16'h4014,
  parameter int          DMA_LEN   = 256,
  parameter bit          ODD_ALIGN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_r_en,
  input  logic [7:0]  cpu_w_data,
  output logic [7:0]  cpu_r_data,
  output logic        cpu_halt,
  output logic        dma_active,
  output reg_t        reg_sel,
  output logic        reg_en,
  output logic        reg_rw,
  output logic [7:0]  reg_data_wr,
  input  logic [7:0]  reg_data_rd,
  output logic [15:0] cart_addr,
  output logic        cart_r_en,
  output logic        cart_w_en,
  output logic [7:0]  cart_w_data,
  input  logic [7:0]  cart_r_data
);

  localparam int         RAM_DEPTH = 1 << RAM_AW;
  localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HALT   = 3'd1,
    S_ALIGN  = 3'd2,
    S_DMA_RD = 3'd3,
    S_DMA_WR = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               halt_r;
  logic               parity_r;
  logic               align_r;
  logic [7:0]         dma_page_r;
  logic [7:0]         dma_idx_r;
  logic [7:0]         dma_buf_r;
  logic [7:0]         cpu_r_data_r;
  logic [7:0]         ram_r [0:RAM_DEPTH-1];

  logic [15:0]        bus_addr_s;
  logic [RAM_AW-1:0]  ram_idx_s;
  logic               sel_ram_s;
  logic               sel_ppu_s;
  logic               sel_int_s;
  logic               sel_cart_s;
  logic               rd_hit_s;
  logic [7:0]         rd_data_s;
  logic               cpu_cyc_s;
  logic               dma_rd_cyc_s;
  logic               dma_wr_cyc_s;
  logic               trigger_s;

  // Bus address source and address decode (DMA reads take over the bus)
  always_comb begin
    bus_addr_s = cpu_addr;
    sel_ram_s  = 1'b0;
    sel_ppu_s  = 1'b0;
    sel_int_s  = 1'b0;
    sel_cart_s = 1'b0;
    if (state_r == S_DMA_RD) begin
      bus_addr_s = {dma_page_r, dma_idx_r};
    end else begin
      bus_addr_s = cpu_addr;
    end
    if (bus_addr_s < 16'h2000) begin
      sel_ram_s = 1'b1;
    end else if (bus_addr_s < 16'h4000) begin
      sel_ppu_s = 1'b1;
    end else if (bus_addr_s == DMA_ADDR) begin
      sel_int_s = 1'b1;
    end else if (bus_addr_s >= 16'h4020) begin
      sel_cart_s = 1'b1;
    end else begin
      // 0x4000-0x401F apart from DMA_ADDR: unmapped
      sel_ram_s = 1'b0;
    end
  end

  assign ram_idx_s = bus_addr_s[RAM_AW-1:0];
  assign rd_hit_s  = sel_ram_s | sel_ppu_s | sel_cart_s;

  // Read data mux; unmapped sources return zero (DMA) or are not loaded (CPU)
  always_comb begin
    rd_data_s = 8'h00;
    if (sel_ram_s) begin
      rd_data_s = ram_r[ram_idx_s];
    end else if (sel_ppu_s) begin
      rd_data_s = reg_data_rd;
    end else if (sel_cart_s) begin
      rd_data_s = cart_r_data;
    end else begin
      rd_data_s = 8'h00;
    end
  end

  assign cpu_cyc_s    = clock_en & (state_r == S_IDLE);
  assign dma_rd_cyc_s = clock_en & (state_r == S_DMA_RD);
  assign dma_wr_cyc_s = clock_en & (state_r == S_DMA_WR);
  assign trigger_s    = (state_r == S_IDLE) & ~cpu_r_en & sel_int_s;

  // PPU register and cartridge strobes, all gated by clock_en
  always_comb begin
    reg_sel     = reg_t'(bus_addr_s[2:0]);
    reg_en      = 1'b0;
    reg_rw      = 1'b0;
    reg_data_wr = cpu_w_data;
    cart_addr   = bus_addr_s;
    cart_r_en   = 1'b0;
    cart_w_en   = 1'b0;
    cart_w_data = cpu_w_data;
    if (dma_wr_cyc_s) begin
      reg_sel     = OAMDATA;
      reg_en      = 1'b1;
      reg_rw      = 1'b1;
      reg_data_wr = dma_buf_r;
    end else if (dma_rd_cyc_s) begin
      reg_en    = sel_ppu_s;
      cart_r_en = sel_cart_s;
    end else if (cpu_cyc_s) begin
      reg_en    = sel_ppu_s;
      reg_rw    = ~cpu_r_en;
      cart_r_en = sel_cart_s & cpu_r_en;
      cart_w_en = sel_cart_s & ~cpu_r_en;
    end else begin
      reg_en = 1'b0;
    end
  end

  // DMA sequencer next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (trigger_s) begin
          state_nxt_s = S_HALT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_HALT: begin
        // align_r holds the cycle parity seen on the triggering write
        if (ODD_ALIGN && align_r) begin
          state_nxt_s = S_ALIGN;
        end else begin
          state_nxt_s = S_DMA_RD;
        end
      end
      S_ALIGN:  state_nxt_s = S_DMA_RD;
      S_DMA_RD: state_nxt_s = S_DMA_WR;
      S_DMA_WR: begin
        if (dma_idx_r == LAST_IDX) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DMA_RD;
        end
      end
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // State register with halt flag and cycle parity
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      halt_r   <= 1'b0;
      parity_r <= 1'b0;
    end else if (clock_en) begin
      state_r  <= state_nxt_s;
      halt_r   <= (state_nxt_s != S_IDLE);
      parity_r <= ~parity_r;
    end
  end

  // Datapath registers: CPU read data, DMA page/index/buffer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_r_data_r <= 8'h00;
      dma_page_r   <= 8'h00;
      dma_idx_r    <= 8'h00;
      dma_buf_r    <= 8'h00;
      align_r      <= 1'b0;
    end else if (clock_en) begin
      case (state_r)
        S_IDLE: begin
          // Unmapped and DMA_ADDR reads leave the previous value (open bus)
          if (cpu_r_en && rd_hit_s) begin
            cpu_r_data_r <= rd_data_s;
          end
          if (trigger_s) begin
            dma_page_r <= cpu_w_data;
            dma_idx_r  <= 8'h00;
            align_r    <= parity_r;
          end
        end
        S_DMA_RD: dma_buf_r <= rd_data_s;
        // 8-bit index wraps inside the page, never carrying into dma_page_r
        S_DMA_WR: dma_idx_r <= dma_idx_r + 8'd1;
        default:  dma_buf_r <= dma_buf_r;
      endcase
    end
  end

  // Work RAM write port; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (cpu_cyc_s && !cpu_r_en && sel_ram_s) begin
      ram_r[ram_idx_s] <= cpu_w_data;
    end
  end

  assign cpu_r_data = cpu_r_data_r;
  assign cpu_halt   = halt_r;
  assign dma_active = halt_r;

endmodule

// File: tb/tb_cpu_bus_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_dma_ctrl
// Randomised scoreboard bench for cpu_bus_dma_ctrl. The stimulus side keeps an
// array model of work RAM and the open-bus value, and queues the expected CPU
// read data and OAM DMA bytes; a negedge monitor pops and compares whenever the
// DUT presents read data or an OAMDATA write. A second instance built without
// odd-cycle alignment runs from the same inputs for the halt-length check.
// -----------------------------------------------------------------------------
module tb_cpu_bus_dma_ctrl;
  import cpu_bus_dma_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clock_en = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_r_en = 1'b1;
  logic [7:0]  cpu_w_data = 8'h00;
  logic [7:0]  reg_data_rd = 8'h00;

  logic [7:0]  cpu_r_data, reg_data_wr, cart_w_data, cart_r_data;
  logic        cpu_halt, dma_active, reg_en, reg_rw, cart_r_en, cart_w_en;
  reg_t        reg_sel;
  logic [15:0] cart_addr;

  logic [7:0]  cpu_r_data0, reg_data_wr0, cart_w_data0, cart_r_data0;
  logic        cpu_halt0, dma_active0, reg_en0, reg_rw0, cart_r_en0, cart_w_en0;
  reg_t        reg_sel0;
  logic [15:0] cart_addr0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  mdl_ram [0:2047];
  logic [7:0]  last_rd;
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  exp_oam_q[$];
  int          en_count = 0;
  int          halt_cnt = 0;
  int          halt_cnt0 = 0;
  int          oam_seen = 0;
  bit          rd_pend = 1'b0;

  always #5 clock = ~clock;

  // Cartridge model: read data is a fixed function of the address
  function automatic logic [7:0] cart_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign cart_r_data  = cart_fn(cart_addr);
  assign cart_r_data0 = cart_fn(cart_addr0);

  cpu_bus_dma_ctrl dut (
    .clock(clock), .reset_n(reset_n), .clock_en(clock_en),
    .cpu_addr(cpu_addr), .cpu_r_en(cpu_r_en), .cpu_w_data(cpu_w_data),
    .cpu_r_data(cpu_r_data), .cpu_halt(cpu_halt), .dma_active(dma_active),
    .reg_sel(reg_sel), .reg_en(reg_en), .reg_rw(reg_rw),
    .reg_data_wr(reg_data_wr), .reg_data_rd(reg_data_rd),
    .cart_addr(cart_addr), .cart_r_en(cart_r_en), .cart_w_en(cart_w_en),
    .cart_w_data(cart_w_data), .cart_r_data(cart_r_data)
  );

  cpu_bus_dma_ctrl #(.ODD_ALIGN(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .clock_en(clock_en),
    .cpu_addr(cpu_addr), .cpu_r_en(cpu_r_en), .cpu_w_data(cpu_w_data),
    .cpu_r_data(cpu_r_data0), .cpu_halt(cpu_halt0), .dma_active(dma_active0),
    .reg_sel(reg_sel0), .reg_en(reg_en0), .reg_rw(reg_rw0),
    .reg_data_wr(reg_data_wr0), .reg_data_rd(reg_data_rd),
    .cart_addr(cart_addr0), .cart_r_en(cart_r_en0), .cart_w_en(cart_w_en0),
    .cart_w_data(cart_w_data0), .cart_r_data(cart_r_data0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one executed CPU access
  task automatic apply_model(input logic [15:0] a, input bit ren, input logic [7:0] wd,
                             input logic [7:0] rr);
    logic [7:0] v;
    if (ren) begin
      if (a < 16'h2000)      v = mdl_ram[a[10:0]];
      else if (a < 16'h4000) v = rr;
      else if (a < 16'h4020) v = last_rd;
      else                   v = cart_fn(a);
      last_rd = v;
      exp_rd_q.push_back(v);
    end else if (a < 16'h2000) begin
      mdl_ram[a[10:0]] = wd;
    end
  endtask

  // Drive one CPU cycle just after the active edge
  task automatic step(input bit en, input logic [15:0] a, input bit ren,
                      input logic [7:0] wd, input logic [7:0] rr, input bit model);
    @(posedge clock);
    #1;
    clock_en    = en;
    cpu_addr    = a;
    cpu_r_en    = ren;
    cpu_w_data  = wd;
    reg_data_rd = rr;
    if (en) en_count++;
    if (model && en) apply_model(a, ren, wd, rr);
  endtask

  // Monitor: read data one cycle after each executed read, OAM writes while halted
  always @(negedge clock) begin
    if (!reset_n) begin
      rd_pend = 1'b0;
    end else begin
      if (rd_pend) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got 0x%0h, expected no read data", cpu_r_data);
        end else begin
          check("cpu_r_data", {24'h0, cpu_r_data}, {24'h0, exp_rd_q.pop_front()});
        end
      end
      rd_pend = clock_en && cpu_r_en && !cpu_halt;
      if (clock_en && cpu_halt)  halt_cnt++;
      if (clock_en && cpu_halt0) halt_cnt0++;
      if (!clock_en) check("strobes_gated", {29'h0, reg_en, cart_r_en, cart_w_en}, 32'h0);
      if (clock_en && cpu_halt && reg_en && reg_rw && reg_sel == OAMDATA) begin
        oam_seen++;
        if (exp_oam_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL oam_extra: got 0x%0h, expected no OAM write", reg_data_wr);
        end else begin
          check("oam_data", {24'h0, reg_data_wr}, {24'h0, exp_oam_q.pop_front()});
        end
      end
    end
  end

  // Trigger a DMA from page, optionally forcing trigger parity; optionally abort at byte 10
  task automatic run_dma(input logic [7:0] page, input int want_par, input bit abort_at10);
    int          par;
    bit          done;
    logic [15:0] a, ja;
    logic [7:0]  jd, jr;
    bit          jren, jen;
    int          oam_at_abort;
    if (want_par >= 0 && (en_count % 2) != want_par) step(1'b1, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b1);
    par = en_count % 2;
    for (int i = 0; i < 256; i++) begin
      a = {page, 8'(i)};
      if (a < 16'h2000) exp_oam_q.push_back(mdl_ram[a[10:0]]);
      else              exp_oam_q.push_back(cart_fn(a));
    end
    halt_cnt = 0;
    halt_cnt0 = 0;
    oam_seen = 0;
    step(1'b1, 16'h4014, 1'b0, page, 8'h00, 1'b0);
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      ja   = 16'($urandom_range(0, 16'h1FFF));
      jren = 1'($urandom_range(0, 1));
      jd   = 8'($urandom);
      jr   = 8'($urandom);
      jen  = ($urandom_range(0, 7) != 0);
      step(jen, ja, jren, jd, jr, 1'b0);
      @(negedge clock);
      if (abort_at10 && oam_seen >= 10) begin
        oam_at_abort = oam_seen;
        reset_n = 1'b0;
        #1;
        check("abort_halt", {30'h0, cpu_halt, dma_active}, 32'h0);
        check("abort_cpu_r_data", {24'h0, cpu_r_data}, 32'h0);
        exp_oam_q.delete();
        exp_rd_q.delete();
        last_rd = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        en_count = 0;
        for (int k = 0; k < 16; k++) begin
          step(1'b1, 16'h0100 + 16'(k), 1'b0, 8'(k) ^ 8'h3C, 8'h00, 1'b1);
          @(negedge clock);
          check("post_abort_idle", {30'h0, reg_en, cpu_halt}, 32'h0);
        end
        for (int k = 0; k < 4; k++) step(1'b1, 16'h0900 + 16'(k * 5), 1'b1, 8'h00, 8'h00, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b0);
        check("post_abort_oam", oam_seen, oam_at_abort);
        return;
      end
      if (!cpu_halt) begin
        done = 1'b1;
        if (jen) apply_model(ja, jren, jd, jr);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL dma_timeout: halt still 1 after 3000 cycles, expected release");
    end else begin
      check("halt_len", halt_cnt, 1 + par + 2 * 256);
      check("halt_len_noalign", halt_cnt0, 1 + 2 * 256);
      check("oam_count", oam_seen, 256);
      check("oam_queue_empty", exp_oam_q.size(), 0);
    end
  endtask

  initial begin
    logic [15:0] ra;
    bit          ren;
    bit          en;
    int          cat;
    last_rd = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("reset_r_data", {24'h0, cpu_r_data}, 32'h0);
    check("reset_halt", {30'h0, cpu_halt, dma_active}, 32'h0);

    // Mirrored RAM
    step(1'b1, 16'h0005, 1'b0, 8'hA5, 8'h00, 1'b1);
    step(1'b1, 16'h0805, 1'b1, 8'h00, 8'h00, 1'b1);
    step(1'b1, 16'h1805, 1'b1, 8'h00, 8'h00, 1'b1);

    // PPU status read
    step(1'b1, 16'h2002, 1'b1, 8'h00, 8'h80, 1'b1);
    @(negedge clock);
    check("ppu_rd_sel", {29'h0, reg_sel}, {29'h0, PPUSTATUS});
    check("ppu_rd_strobe", {30'h0, reg_en, reg_rw}, 32'h2);

    // Open bus on unmapped 0x4016
    step(1'b1, 16'h2000, 1'b1, 8'h00, 8'h3C, 1'b1);
    step(1'b1, 16'h4016, 1'b1, 8'h00, 8'h77, 1'b1);
    @(negedge clock);
    check("unmapped_strobes", {29'h0, reg_en, cart_r_en, cart_w_en}, 32'h0);

    // Cartridge write
    step(1'b1, 16'h6000, 1'b0, 8'h99, 8'h00, 1'b1);
    @(negedge clock);
    check("cart_wr", {7'h0, cart_w_en, cart_addr, cart_w_data}, {7'h0, 1'b1, 16'h6000, 8'h99});

    // Fill RAM; page 2 holds its own index
    for (int i = 0; i < 2048; i++) begin
      if (i >= 16'h200 && i < 16'h300) step(1'b1, 16'(i), 1'b0, 8'(i), 8'h00, 1'b1);
      else                             step(1'b1, 16'(i), 1'b0, 8'($urandom), 8'h00, 1'b1);
    end

    run_dma(8'h02, 0, 1'b0);
    run_dma(8'h02, 1, 1'b0);
    run_dma(8'h80, -1, 1'b0);

    // Random CPU traffic over all regions
    for (int n = 0; n < 400; n++) begin
      cat = $urandom_range(0, 3);
      case (cat)
        0:       ra = 16'($urandom_range(0, 16'h1FFF));
        1:       ra = 16'($urandom_range(16'h2000, 16'h3FFF));
        2:       ra = 16'($urandom_range(16'h4000, 16'h401F));
        default: ra = 16'($urandom_range(16'h4020, 16'hFFFF));
      endcase
      ren = 1'($urandom_range(0, 1));
      if (ra == 16'h4014) ren = 1'b1;
      en = ($urandom_range(0, 9) != 0);
      step(en, ra, ren, 8'($urandom), 8'($urandom), 1'b1);
    end
    run_dma(8'h0A, -1, 1'b0);
    run_dma(8'h03, -1, 1'b1);

    step(1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b0);
    @(negedge clock);
    check("rd_queue_empty", exp_rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
